game_txt_reveal_ctrl: RTL and testbench

- Typewriter-style sequencer for the on-screen game text content ROMs.
- Sits between the text renderer (which issues character cell addresses) and the page ROMs (char_xy -> char_code, 1-cycle registered).
- After a start, reveals one character every FRAME_DIV frames and masks not-yet-revealed cells to SPACE.
- Selects which text page the ROM mux serves, and reports busy/done to the game FSM.

---
 rtl/game_txt_reveal_ctrl.sv | 94 +++++++++
 tb/tb_game_txt_reveal_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_txt_reveal_ctrl.sv
// rtl/game_txt_reveal_ctrl.sv - typewriter reveal sequencer between text renderer and page ROMs
module game_txt_reveal_ctrl #(
    parameter int          FRAME_DIV = 3,
    parameter logic [7:0]  LAST_CHAR = 8'h7F,
    parameter int          PAGE_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PAGE_W-1:0] page_sel,
    input  logic              skip,
    input  logic              frame_tick,
    input  logic [7:0]        draw_xy,
    output logic [7:0]        rom_xy,
    output logic [PAGE_W-1:0] rom_page,
    input  logic [6:0]        rom_code,
    output logic [6:0]        char_code,
    output logic              busy,
    output logic              done
);

    localparam int                FCNT_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [8:0]        PTR_FULL  = {1'b0, LAST_CHAR} + 9'd1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAME_DIV - 1);
    localparam logic [6:0]        SPACE     = 7'h20;

    typedef enum logic [1:0] {IDLE, TYPE, HOLD} state_t;

    state_t              state, state_nx;
    logic [8:0]          ptr, ptr_nx;
    logic [FCNT_W-1:0]   fcnt, fcnt_nx;
    logic [PAGE_W-1:0]   page_nx;
    logic                vis, vis_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            fcnt     <= '0;
            rom_page <= '0;
            vis_d    <= 1'b0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            fcnt     <= fcnt_nx;
            rom_page <= page_nx;
            vis_d    <= vis;
        end
    end

    // start outranks skip, skip outranks frame_tick; a tick on the start cycle is dropped
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        fcnt_nx  = fcnt;
        page_nx  = rom_page;
        if (start) begin
            state_nx = TYPE;
            ptr_nx   = '0;
            fcnt_nx  = '0;
            page_nx  = page_sel;
        end else begin
            case (state)
                TYPE: begin
                    if (skip) begin
                        ptr_nx   = PTR_FULL;
                        state_nx = HOLD;
                    end else if (frame_tick) begin
                        if (fcnt == FCNT_LAST) begin
                            fcnt_nx = '0;
                            ptr_nx  = ptr + 9'd1;
                            if (ptr + 9'd1 == PTR_FULL) begin
                                state_nx = HOLD;
                            end
                        end else begin
                            fcnt_nx = fcnt + 1'b1;
                        end
                    end
                end
                IDLE, HOLD: begin
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // visibility lines up with the 1-cycle ROM read so renderer latency is unchanged
    assign vis       = (state == HOLD) | ((state == TYPE) & ({1'b0, draw_xy} < ptr));
    assign rom_xy    = draw_xy;
    assign char_code = vis_d ? rom_code : SPACE;
    assign busy      = (state == TYPE);
    assign done      = (state == HOLD);

endmodule

// File: tb/tb_game_txt_reveal_ctrl.sv
// tb/tb_game_txt_reveal_ctrl.sv - randomized self-checking bench for game_txt_reveal_ctrl
module tb_game_txt_reveal_ctrl;

    localparam int         FD    = 2;
    localparam logic [7:0] LAST  = 8'h2F;
    localparam int         NCELL = 48;
    localparam logic [6:0] SP    = 7'h20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] page_sel = '0;
    logic       skip = 1'b0;
    logic       frame_tick = 1'b0;
    logic [7:0] draw_xy = '0;
    logic [7:0] rom_xy;
    logic [1:0] rom_page;
    logic [6:0] rom_code = '0;
    logic [6:0] char_code;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    // reference: mode 0 idle, 1 typing, 2 all shown; revealed = accepted ticks / FD
    int         m_mode = 0;
    int         m_ticks = 0;
    logic [1:0] m_page = '0;
    logic       m_vis_d = 1'b0;

    game_txt_reveal_ctrl #(.FRAME_DIV(FD), .LAST_CHAR(LAST), .PAGE_W(2)) dut (
        .clk(clk), .rst(rst), .start(start), .page_sel(page_sel), .skip(skip),
        .frame_tick(frame_tick), .draw_xy(draw_xy), .rom_xy(rom_xy), .rom_page(rom_page),
        .rom_code(rom_code), .char_code(char_code), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int revealed();
        int r;
        r = m_ticks / FD;
        return (r > NCELL) ? NCELL : r;
    endfunction

    function automatic logic model_vis(input logic [7:0] xy);
        return (m_mode == 2) || (m_mode == 1 && int'(xy) < revealed());
    endfunction

    task automatic step(input logic r, input logic s, input logic [1:0] p,
                        input logic k, input logic t, input logic [7:0] xy);
        logic v;
        rst = r; start = s; page_sel = p; skip = k; frame_tick = t; draw_xy = xy;
        rom_code = 7'($urandom);
        v = model_vis(xy);
        @(posedge clk);
        if (r) begin
            m_mode = 0; m_ticks = 0; m_page = '0; m_vis_d = 1'b0;
        end else begin
            m_vis_d = v;
            if (s) begin
                m_mode = 1; m_ticks = 0; m_page = p;
            end else if (m_mode == 1 && k) begin
                m_mode = 2;
            end else if (m_mode == 1 && t) begin
                m_ticks++;
                if (m_ticks / FD >= NCELL) m_mode = 2;
            end
        end
        #1;
        rst = 1'b0; start = 1'b0; skip = 1'b0; frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 0, 8'h05);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rom_page !== 2'd0) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b page=%0d required 0 0 0", busy, done, rom_page);
        end
        checks++;
        if (char_code !== SP) begin
            errors++;
            $display("FAIL reset_char got %h required %h", char_code, SP);
        end
        step(0, 0, 0, 1, 1, 8'h00);
        step(0, 0, 0, 0, 0, 8'h00);
        checks++;
        if (char_code !== SP || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignores_skip char=%h busy=%b done=%b required %h 0 0", char_code, busy, done, SP);
        end
    endtask

    task automatic test_basic_reveal();
        step(0, 1, 2'd1, 0, 0, 8'h00);
        checks++;
        if (busy !== 1'b1 || rom_page !== 2'd1) begin
            errors++;
            $display("FAIL basic_start busy=%b page=%0d required 1 1", busy, rom_page);
        end
        step(0, 0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 0, 0, 8'h00);
        checks++;
        if (char_code !== rom_code) begin
            errors++;
            $display("FAIL basic_cell0 got %h required %h", char_code, rom_code);
        end
        step(0, 0, 0, 0, 0, 8'h01);
        checks++;
        if (char_code !== SP) begin
            errors++;
            $display("FAIL basic_cell1 got %h required %h", char_code, SP);
        end
        for (int i = 2; i < NCELL * FD; i++) begin
            step(0, 0, 0, 0, 1, 8'(i % NCELL));
            if (i < NCELL * FD - 1) begin
                checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_typing tick=%0d busy=%b done=%b required 1 0", i, busy, done);
                end
            end
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL basic_done busy=%b done=%b required 0 1", busy, done);
        end
        for (int a = 0; a < NCELL; a++) begin
            step(0, 0, 0, 0, 1, 8'(a));
            checks++;
            if (char_code !== rom_code) begin
                errors++;
                $display("FAIL basic_all_visible xy=%h got %h required %h", a, char_code, rom_code);
            end
        end
    endtask

    task automatic test_skip();
        step(0, 1, 2'd3, 0, 0, 8'h00);
        step(0, 0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 1, 0, 8'h00);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL skip_done done=%b busy=%b required 1 0", done, busy);
        end
        step(0, 0, 0, 0, 0, 8'h7F);
        checks++;
        if (char_code !== rom_code) begin
            errors++;
            $display("FAIL skip_7f got %h required %h", char_code, rom_code);
        end
    endtask

    task automatic test_restart();
        step(0, 1, 2'd0, 0, 0, 8'h00);
        for (int i = 0; i < 5 * FD; i++) step(0, 0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 0, 0, 8'h04);
        checks++;
        if (char_code !== rom_code) begin
            errors++;
            $display("FAIL restart_ptr5 got %h required %h", char_code, rom_code);
        end
        step(0, 1, 2'd2, 0, 0, 8'h05);
        step(0, 0, 0, 0, 0, 8'h00);
        checks++;
        if (rom_page !== 2'd2 || busy !== 1'b1 || char_code !== SP) begin
            errors++;
            $display("FAIL restart page=%0d busy=%b char=%h required 2 1 %h", rom_page, busy, char_code, SP);
        end
    endtask

    task automatic test_collisions();
        step(0, 1, 2'd1, 1, 0, 8'h00);
        step(0, 0, 0, 0, 0, 8'h00);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || char_code !== SP) begin
            errors++;
            $display("FAIL start_skip busy=%b done=%b char=%h required 1 0 %h", busy, done, char_code, SP);
        end
        step(0, 1, 2'd1, 0, 1, 8'h00);
        step(0, 0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 0, 0, 8'h00);
        checks++;
        if (char_code !== SP) begin
            errors++;
            $display("FAIL start_tick_fcnt got %h required %h", char_code, SP);
        end
        step(0, 0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 0, 0, 8'h00);
        checks++;
        if (char_code !== rom_code) begin
            errors++;
            $display("FAIL start_tick_advance got %h required %h", char_code, rom_code);
        end
        step(0, 0, 0, 1, 1, 8'h00);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL skip_tick done=%b busy=%b required 1 0", done, busy);
        end
    endtask

    task automatic test_reset_mid();
        step(0, 1, 2'd3, 0, 0, 8'h00);
        for (int i = 0; i < 40 * FD; i++) step(0, 0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 0, 0, 8'h27);
        checks++;
        if (char_code !== rom_code) begin
            errors++;
            $display("FAIL ptr40_last_visible got %h required %h", char_code, rom_code);
        end
        step(0, 0, 0, 0, 0, 8'h28);
        checks++;
        if (char_code !== SP || busy !== 1'b1) begin
            errors++;
            $display("FAIL ptr40_first_masked char=%h busy=%b required %h 1", char_code, busy, SP);
        end
        step(0, 0, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 0, 8'h00);
        checks++;
        if (char_code !== SP || busy !== 1'b0 || done !== 1'b0 || rom_page !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid char=%h busy=%b done=%b page=%0d required %h 0 0 0",
                     char_code, busy, done, rom_page, SP);
        end
    endtask

    task automatic test_random();
        logic       r, s, k, t;
        logic [1:0] p;
        logic [7:0] xy;
        logic [6:0] exp_char;
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 299) == 0);
            s  = ($urandom_range(0, 119) == 0);
            k  = ($urandom_range(0, 149) == 0);
            t  = ($urandom_range(0, 2) == 0);
            p  = 2'($urandom);
            xy = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, NCELL + 2));
            step(r, s, p, k, t, xy);
            exp_char = m_vis_d ? rom_code : SP;
            checks++;
            if (char_code !== exp_char || busy !== (m_mode == 1) || done !== (m_mode == 2) ||
                rom_page !== m_page || rom_xy !== draw_xy) begin
                errors++;
                $display("FAIL random n=%0d char=%h/%h busy=%b/%b done=%b/%b page=%0d/%0d xy=%h/%h",
                         n, char_code, exp_char, busy, (m_mode == 1), done, (m_mode == 2),
                         rom_page, m_page, rom_xy, draw_xy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_reveal();
        test_skip();
        test_restart();
        test_collisions();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
